prog_loader: RTL

Byte-stream program loader: the writer side of the CPU instruction/data memory that the controller reads.
- Accepts a length-prefixed byte stream over a valid/ready handshake.
- Assembles 16-bit words, high byte first, and writes them into consecutive memory locations.
- Holds the CPU in reset while loading and releases it once the image is complete.

---
 rtl/prog_loader.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: turns a length-prefixed byte stream into 16-bit words (high byte first) written to CPU memory; holds the CPU in reset until loaded.
// Latency: one word per 3 cycles at best (two byte cycles + one write cycle); done rises the cycle after the last write, cpu_reset falls one cycle later.
// Backpressure: in_ready is low during the write cycle and outside loading; in_valid low stalls forever. Optional trailing XOR checksum byte: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    // Number of words that fit between BASE_ADDR and the top of memory.
    localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [16:0]           MAX_WORDS = 17'(DEPTH - BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    // Where the load goes once every word is in (or straight after a zero length).
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = S_CSUM;
`else
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [15:0] len_q;
    logic [7:0]  byte_hi_q;
    logic        xfer;
    logic        start_load;
    logic [16:0] len_in;
    logic        last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    // A byte moves whenever both sides agree; start only counts when not already loading.
    assign xfer       = in_valid && in_ready;
    assign start_load = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));

    // Full length as it completes in LEN_LO, widened so the bound check cannot wrap.
    assign len_in     = {1'b0, len_q[15:8], in_data};

    // The word being written in WRITE is the last one of the image.
    assign last_word  = (17'(words_loaded) + 17'd1) == {1'b0, len_q};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision: byte states advance on a transfer, WRITE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_in > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (len_in == 17'd0) begin
                        state_d = S_AFTER_LAST;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = last_word ? S_AFTER_LAST : S_DATA_HI;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Capture the length, high byte first.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= 16'h0000;
        end else if (xfer && (state_q == S_LEN_HI)) begin
            len_q[15:8] <= in_data;
        end else if (xfer && (state_q == S_LEN_LO)) begin
            len_q[7:0] <= in_data;
        end
    end

    // Hold the high data byte until its partner arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_hi_q <= 8'h00;
        end else if (xfer && (state_q == S_DATA_HI)) begin
            byte_hi_q <= in_data;
        end
    end

    // Load the write port as the low byte lands so it is ready in WRITE; it then holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= 16'h0000;
        end else if (xfer && (state_q == S_DATA_LO)) begin
            mem_addr  <= BASE + words_loaded[ADDR_WIDTH-1:0];
            mem_wdata <= {byte_hi_q, in_data};
        end
    end

    // Words written so far in this load; also the index of the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_loaded <= '0;
        end else if (start_load) begin
            words_loaded <= '0;
        end else if (state_q == S_WRITE) begin
            words_loaded <= words_loaded + ONE_WORD;
        end
    end

    // Release the CPU only after a full cycle in DONE; any new start grabs it back at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset <= 1'b1;
        end else begin
            cpu_reset <= !((state_q == S_DONE) && (state_d == S_DONE));
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR over data bytes only; the length prefix is not covered.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else if (start_load) begin
            csum_q <= 8'h00;
        end else if (xfer && ((state_q == S_DATA_HI) || (state_q == S_DATA_LO))) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

endmodule
